// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed common-anode seven-segment driver with double-buffered data
// Ports: clk, rst (sync active-high); load strobes data_in/dp_in/en_in into the pending buffer;
// seg/an_out/dp are active-low registered pin drives; frame_start pulses at the digit-0 slot;
// pending flags loaded data not yet applied. Define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    dp,
  output logic                    frame_start,
  output logic                    pending
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pending_q, wrap, upd, lit, dp_q, dp_d, fs_q;
  logic [4*NUM_DIGITS-1:0] pd_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pd_dp_q, pd_en_q, act_dp_q, act_en_q, an_q, an_d, blank;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              nib;
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001; 4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010; 4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100; 4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000; 4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000; 4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000; 4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001; 4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000; default: glyph = 7'b0111000;
    endcase
  endfunction
`ifdef SEVEN_SEG_LZB_EN
  logic [NUM_DIGITS-1:0] blank_q;
  // Scanning down from the top digit: once a nonzero nibble or a set dp is seen, everything below stays lit.
  function automatic logic [NUM_DIGITS-1:0] lzb(input logic [4*NUM_DIGITS-1:0] d, input logic [NUM_DIGITS-1:0] p);
    logic [NUM_DIGITS-1:0] m;
    logic keep;
    keep = 1'b0;
    m = '0;
    for (int k = NUM_DIGITS-1; k >= 0; k--) begin
      keep = keep | (d[4*k +: 4] != 4'd0) | p[k];
      m[k] = !keep && (k != 0);
    end
    return m;
  endfunction
  always_ff @(posedge clk)
    if (rst) blank_q <= '0;
    else if (upd) blank_q <= load ? lzb(data_in, dp_in) : lzb(pd_data_q, pd_dp_q);
  assign blank = blank_q;
`else
  assign blank = '0;
`endif
  always_comb begin
    wrap  = (cnt_q == CW'(SCAN_DIV-1)) && (idx_q == IW'(NUM_DIGITS-1));
    upd   = wrap && (load || pending_q);
    cnt_d = (cnt_q == CW'(SCAN_DIV-1)) ? '0 : cnt_q + 1'b1;
    idx_d = (cnt_q != CW'(SCAN_DIV-1)) ? idx_q : (idx_q == IW'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
    nib   = act_data_q[4*idx_q +: 4];
    lit   = (cnt_q >= CW'(DEAD_CYC)) && act_en_q[idx_q] && !blank[idx_q];
    seg_d = lit ? glyph(nib) : 7'h7f;
    an_d  = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    dp_d  = !(lit && act_dp_q[idx_q]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      pd_data_q  <= '0;
      pd_dp_q    <= '0;
      pd_en_q    <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      seg_q      <= 7'h7f;
      an_q       <= '1;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= !wrap && (pending_q || load);
      if (load) {pd_data_q, pd_dp_q, pd_en_q} <= {data_in, dp_in, en_in};
      // A load on the wrap edge bypasses the pending buffer and lands directly in the active one.
      if (upd) {act_data_q, act_dp_q, act_en_q} <= load ? {data_in, dp_in, en_in} : {pd_data_q, pd_dp_q, pd_en_q};
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      fs_q      <= (cnt_q == '0) && (idx_q == '0);
    end
  assign seg         = seg_q;
  assign an_out      = an_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;
  assign pending     = pending_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed and random stimulus checked cycle by cycle against a behavioural display model
module tb_seven_seg_scan;
  localparam int ND = 4, SD = 8, DC = 2, FR = ND*SD;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0, en_in = '0;
  logic [6:0] seg;
  logic [3:0] an_out;
  logic dp, frame_start, pending;
  int compared = 0, mismatched = 0;
  int n = 0;
  logic [15:0] ad = '0, pd = '0;
  logic [3:0] adp = '0, aen = '0, pdp = '0, pen = '0, amask = '0;
  bit pnd = 0;
  logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  always #5 clk = ~clk;
  seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
    .seg(seg), .an_out(an_out), .dp(dp), .frame_start(frame_start), .pending(pending));
  function automatic logic [3:0] mask_of(input logic [15:0] d, input logic [3:0] p);
    logic [3:0] m;
    m = '0;
`ifdef SEVEN_SEG_LZB_EN
    for (int k = 1; k < ND; k++) m[k] = ((d >> (4*k)) == 0) && ((p >> k) == 0);
`endif
    return m;
  endfunction
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s at n=%0d: observed %b expected %b", tag, n, got, exp);
    end
  endtask
  task automatic tick(input bit r, input bit ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    int c, i;
    bit lit, wrap;
    logic [3:0] nib, ea;
    logic [6:0] es;
    logic edp, efs;
    rst = r; load = ld; data_in = d; dp_in = p; en_in = e;
    c = n % SD;
    i = (n / SD) % ND;
    nib = 4'(ad >> (4*i));
    lit = !r && c >= DC && aen[i] && !amask[i];
    es = lit ? glyph[nib] : 7'h7f;
    ea = lit ? ~(4'd1 << i) : 4'hF;
    edp = !(lit && adp[i]);
    efs = !r && (n % FR == 0);
    @(posedge clk);
    if (r) begin
      n = 0; ad = '0; pd = '0; adp = '0; aen = '0; pdp = '0; pen = '0; amask = '0; pnd = 0;
    end else begin
      wrap = (n % FR) == FR-1;
      if (wrap && (ld || pnd)) begin
        {ad, adp, aen} = ld ? {d, p, e} : {pd, pdp, pen};
        amask = mask_of(ad, adp);
        pnd = 0;
      end else if (ld) pnd = 1;
      if (ld) {pd, pdp, pen} = {d, p, e};
      n++;
    end
    #1;
    chk("seg", seg, es);
    chk("an_out", 7'(an_out), 7'(ea));
    chk("dp", 7'(dp), 7'(edp));
    chk("frame_start", 7'(frame_start), 7'(efs));
    chk("pending", 7'(pending), 7'(pnd));
  endtask
  task automatic idle(input int k);
    for (int j = 0; j < k; j++) tick(0, 0, 16'h0, 4'h0, 4'h0);
  endtask
  task automatic run_to(input int pos);
    for (int j = 0; j < FR && (n % FR) != pos; j++) tick(0, 0, 16'h0, 4'h0, 4'h0);
  endtask
  initial begin
    for (int j = 0; j < 3; j++) tick(1, 0, 16'h0, 4'h0, 4'h0);
    idle(70);
    run_to(5);
    tick(0, 1, 16'h3A91, 4'h0, 4'hF);
    idle(80);
    run_to(3);
    tick(0, 1, 16'h1111, 4'h2, 4'hF);
    idle(6);
    tick(0, 1, 16'h2222, 4'h1, 4'hF);
    idle(70);
    run_to(FR-1);
    tick(0, 1, 16'h0005, 4'h0, 4'h1);
    chk("pending_after_wrap_load", 7'(pending), 7'd0);
    idle(40);
    run_to(2*SD + 1);
    tick(0, 1, 16'hBEEF, 4'hF, 4'hF);
    idle(2);
    tick(1, 0, 16'h0, 4'h0, 4'h0);
    chk("pending_after_reset", 7'(pending), 7'd0);
    idle(40);
    tick(0, 1, 16'h0040, 4'h0, 4'hF);
    idle(70);
    tick(0, 1, 16'h0040, 4'h4, 4'hF);
    idle(70);
    for (int j = 0; j < 2000; j++)
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for a common-anode seven-segment display with a parameterised digit count. It sits between the register or datapath logic that produces hex nibbles and the board pins. Each digit is lit in turn at a programmable scan rate, with anti-ghosting dead time between digits. Display updates are double-buffered, so a frame never shows a mix of old and new data.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16).
- SCAN_DIV, 100000, clock cycles per digit slot (≥ 4).
- DEAD_CYC, 2, cycles at the start of each slot with all anodes off (1 ≤ DEAD_CYC < SCAN_DIV).

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe that captures data_in, dp_in and en_in into the pending buffer.
- data_in  in  4*NUM_DIGITS  nibble k = data_in[4k+3:4k] is the value for digit k; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, active high.
- en_in  in  NUM_DIGITS  per-digit enable; 0 blanks the digit.
- seg  out  7  cathodes, active low; seg[6]=a … seg[0]=g.
- an_out  out  NUM_DIGITS  anodes, active low, at most one low at a time.
- dp  out  1  decimal-point cathode, active low.
- frame_start  out  1  one-cycle pulse at the start of the digit-0 slot.
- pending  out  1  high while loaded data is waiting to be applied.

## Operation
- **Prescaler and index.**
  - Prescaler cnt counts 0..SCAN_DIV-1 and wraps.
  - When cnt = SCAN_DIV-1, digit index idx advances: 0, 1, …, NUM_DIGITS-1, then wraps to 0.
- **Double buffering.**
  - load writes the pending buffer and sets pending.
  - A second load before the buffer is applied overwrites it; the last load wins.
  - At the wrap edge (cnt = SCAN_DIV-1 and idx = NUM_DIGITS-1):
    - If pending is set, the pending buffer is copied to the active buffer and pending clears.
    - If load is high on the wrap edge itself, the incoming load data goes straight to the active buffer and pending is cleared.
- **Glyphs** (abcdefg, active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **Output computation.** Outputs are registered. On each edge:
  - If cnt < DEAD_CYC, or active en[idx] = 0: an_out is all ones, seg = 1111111, dp = 1.
  - Otherwise: an_out = ~(1 << idx), seg = glyph(active nibble idx), dp = ~active dp[idx].
- **frame_start.** Registered; high for the single cycle that follows the state cnt = 0, idx = 0.
- **Reset.**
  - Internal state: cnt = 0, idx = 0, both buffers zero (en = 0), pending = 0.
  - Outputs: an_out all ones, seg = 1111111, dp = 1, frame_start = 0.
  - Reset asserted mid-frame discards pending data and restarts the scan at digit 0.

## Timing
- Outputs lag the internal cnt/idx state by one cycle.
- Each digit is lit for SCAN_DIV-DEAD_CYC cycles per slot, and all digits are dark for DEAD_CYC cycles at each slot boundary.
- Frame period is NUM_DIGITS*SCAN_DIV cycles.
- The first frame_start pulse occurs on the second cycle after rst deasserts; subsequent pulses follow every frame period.
- Load-to-display latency is at most one frame period plus 1+DEAD_CYC cycles.
- pending rises the cycle after load and falls the cycle after the wrap edge.

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking is enabled.
  - When the active buffer is updated, a registered blank mask is computed.
  - Every digit above the most-significant nonzero nibble is treated as disabled.
  - Digit 0 is never blanked by this rule.
  - dp[k] = 1 keeps digit k and all digits below it unblanked.
- Macro undefined: digits are blanked only by en_in; there is no mask logic.

## Test plan
Unless stated, all scenarios use NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2.
- **Reset:** hold rst for 3 cycles, then release with no load → an_out=1111 and seg=1111111 for all cycles; frame_start pulses every 32 cycles.
- **Load and scan:** load data_in=16'h3A91, en_in=1111 → after the next wrap, slots show digit 0 seg=1001111 (1), digit 1 seg=0000100 (9), digit 2 seg=0001000 (A), digit 3 seg=0000110 (3). Each digit is lit for 6 cycles with an_out one-cold, with 2 dark cycles between digits.
- **Overwrite:** two loads mid-frame (16'h1111, then 16'h2222) → only 2222 is ever displayed; pending clears the cycle after the wrap.
- **Load on wrap edge:** load 16'h0005 on the exact wrap edge → digit 0 shows 5 in the very next frame; pending stays 0.
- **Reset mid-operation:** rst during digit 2 with pending set → all outputs blank, pending=0, scan restarts at digit 0.
- **Leading-zero blanking:** with SEVEN_SEG_LZB_EN defined, load 16'h0040, dp_in=0000 → digits 3 and 2 stay dark, digits 1 and 0 show 4 and 0. Then load 16'h0040, dp_in=0100 → digit 2 shows 0, digit 3 stays dark.
